strand_wake_controller: RTL and testbench

- Per-strand sleep/wake scheduler downstream of the writeback stage.
- Consumes writeback rollback, suspend and retry indications tagged with a strand index.
- Tracks which strands are runnable and applies exponential-free linear backoff to strands that keep hitting load collisions.
- Drives the strand-ready mask to the strand select stage and a registered rollback command to the front of the pipeline.

---
 rtl/strand_wake_controller.sv | 191 +++++++++++++++++++
 tb/tb_strand_wake_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/strand_wake_controller.sv
// rtl/strand_wake_controller.sv - per-strand sleep/wake scheduler downstream of writeback
//
// Tracks each hardware strand as RUNNING, SUSPENDED (waiting on a fill) or
// BACKOFF (linear retry backoff after load collisions). It drives the issue
// ready mask and forwards a registered rollback command to the pipeline front.
//
// Optional feature macro: STRAND_WAKE_PERF_EN (adds performance event pulses).
//
// Ports:
//   clk                      clock
//   reset                    asynchronous active-high reset
//   wb_rollback_request      writeback requests rollback of wb_strand
//   wb_rollback_pc           restart PC for the rollback
//   wb_suspend_request       rollback is a miss/stall; strand sleeps until resumed
//   wb_retry                 rollback is a load collision; strand backs off
//   wb_strand                strand owning the writeback instruction
//   resume_strands           wake mask from dcache / store buffer fills
//   strand_enable            control-register strand enable mask
//   strand_ready             strands eligible for issue (combinational)
//   rollback_en              registered rollback command valid
//   rollback_strand          strand to roll back
//   rollback_pc              PC to restart at
//   strand_sleeping          strands currently SUSPENDED
//   pc_event_strand_suspend  (STRAND_WAKE_PERF_EN) pulse per SUSPENDED entry
//   pc_event_retry_backoff   (STRAND_WAKE_PERF_EN) pulse per BACKOFF entry

module strand_wake_controller #(
  parameter int NUM_STRANDS        = 4,
  parameter int STRAND_INDEX_WIDTH = 2,
  parameter int MAX_BACKOFF        = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wb_rollback_request,
  input  logic [31:0]                   wb_rollback_pc,
  input  logic                          wb_suspend_request,
  input  logic                          wb_retry,
  input  logic [STRAND_INDEX_WIDTH-1:0] wb_strand,
  input  logic [NUM_STRANDS-1:0]        resume_strands,
  input  logic [NUM_STRANDS-1:0]        strand_enable,
  output logic [NUM_STRANDS-1:0]        strand_ready,
  output logic                          rollback_en,
  output logic [STRAND_INDEX_WIDTH-1:0] rollback_strand,
  output logic [31:0]                   rollback_pc,
  output logic [NUM_STRANDS-1:0]        strand_sleeping
`ifdef STRAND_WAKE_PERF_EN
  ,
  output logic                          pc_event_strand_suspend,
  output logic                          pc_event_retry_backoff
`endif
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BACKOFF);

  typedef enum logic [1:0] {
    ST_RUNNING   = 2'd0,
    ST_SUSPENDED = 2'd1,
    ST_BACKOFF   = 2'd2
  } strand_state_t;

  strand_state_t    state_q     [NUM_STRANDS];
  logic [CNT_W-1:0] backoff_cnt [NUM_STRANDS];
  logic [CNT_W-1:0] retry_cnt   [NUM_STRANDS];

  logic [NUM_STRANDS-1:0] event_hit;

  // Saturating increment; used both for the backoff load (retry_count+1)
  // and for advancing retry_count, so both cap at MAX_BACKOFF.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_CNT) begin
      return MAX_CNT;
    end
    return v + 1'b1;
  endfunction

  always_comb begin
    event_hit = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      event_hit[s] = wb_rollback_request && (wb_strand == STRAND_INDEX_WIDTH'(s));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rollback_en     <= 1'b0;
      rollback_strand <= '0;
      rollback_pc     <= '0;
      for (int s = 0; s < NUM_STRANDS; s++) begin
        state_q[s]     <= ST_RUNNING;
        backoff_cnt[s] <= '0;
        retry_cnt[s]   <= '0;
      end
    end else begin
      // Rollbacks are always forwarded, whatever state the strand is in.
      rollback_en <= wb_rollback_request;
      if (wb_rollback_request) begin
        rollback_strand <= wb_strand;
        rollback_pc     <= wb_rollback_pc;
      end

      for (int s = 0; s < NUM_STRANDS; s++) begin
        if (!strand_enable[s]) begin
          // A disabled strand is parked as RUNNING with clean counters so
          // re-enabling it makes it issue-ready without needing a resume.
          state_q[s]     <= ST_RUNNING;
          backoff_cnt[s] <= '0;
          retry_cnt[s]   <= '0;
        end else begin
          case (state_q[s])
            ST_RUNNING: begin
              if (event_hit[s]) begin
                if (wb_suspend_request) begin
                  retry_cnt[s] <= '0;
                  // A fill arriving in the same cycle beats the sleep.
                  if (!resume_strands[s]) begin
                    state_q[s] <= ST_SUSPENDED;
                  end
                end else if (wb_retry) begin
                  state_q[s]     <= ST_BACKOFF;
                  backoff_cnt[s] <= sat_inc(retry_cnt[s]);
                  retry_cnt[s]   <= sat_inc(retry_cnt[s]);
                end else begin
                  retry_cnt[s] <= '0;
                end
              end
            end
            ST_SUSPENDED: begin
              if (resume_strands[s]) begin
                state_q[s]   <= ST_RUNNING;
                retry_cnt[s] <= '0;
              end
            end
            ST_BACKOFF: begin
              // Load N leaves the strand not-ready for exactly N cycles.
              if (backoff_cnt[s] <= 1) begin
                state_q[s]     <= ST_RUNNING;
                backoff_cnt[s] <= '0;
              end else begin
                backoff_cnt[s] <= backoff_cnt[s] - 1'b1;
              end
            end
            default: begin
              state_q[s]     <= ST_RUNNING;
              backoff_cnt[s] <= '0;
              retry_cnt[s]   <= '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    strand_ready    = '0;
    strand_sleeping = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      strand_ready[s]    = strand_enable[s] && (state_q[s] == ST_RUNNING);
      strand_sleeping[s] = (state_q[s] == ST_SUSPENDED);
    end
  end

`ifdef STRAND_WAKE_PERF_EN
  logic [NUM_STRANDS-1:0] enter_suspend;
  logic [NUM_STRANDS-1:0] enter_backoff;

  // Mirrors the RUNNING-state transitions above so each pulse lines up
  // with the cycle the strand is first seen in its new state.
  always_comb begin
    enter_suspend = '0;
    enter_backoff = '0;
    for (int s = 0; s < NUM_STRANDS; s++) begin
      if (strand_enable[s] && (state_q[s] == ST_RUNNING) && event_hit[s]) begin
        enter_suspend[s] = wb_suspend_request && !resume_strands[s];
        enter_backoff[s] = !wb_suspend_request && wb_retry;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_event_strand_suspend <= 1'b0;
      pc_event_retry_backoff  <= 1'b0;
    end else begin
      pc_event_strand_suspend <= |enter_suspend;
      pc_event_retry_backoff  <= |enter_backoff;
    end
  end
`endif

endmodule

// File: tb/tb_strand_wake_controller.sv
// tb/tb_strand_wake_controller.sv - directed self-checking bench for strand_wake_controller

module tb_strand_wake_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_rollback_request;
  logic [31:0] wb_rollback_pc;
  logic        wb_suspend_request;
  logic        wb_retry;
  logic [1:0]  wb_strand;
  logic [3:0]  resume_strands;
  logic [3:0]  strand_enable;
  logic [3:0]  strand_ready;
  logic        rollback_en;
  logic [1:0]  rollback_strand;
  logic [31:0] rollback_pc;
  logic [3:0]  strand_sleeping;
`ifdef STRAND_WAKE_PERF_EN
  logic        pc_event_strand_suspend;
  logic        pc_event_retry_backoff;
`endif

  int total = 0;
  int bad   = 0;

  strand_wake_controller dut (
    .clk                 (clk),
    .reset               (reset),
    .wb_rollback_request (wb_rollback_request),
    .wb_rollback_pc      (wb_rollback_pc),
    .wb_suspend_request  (wb_suspend_request),
    .wb_retry            (wb_retry),
    .wb_strand           (wb_strand),
    .resume_strands      (resume_strands),
    .strand_enable       (strand_enable),
    .strand_ready        (strand_ready),
    .rollback_en         (rollback_en),
    .rollback_strand     (rollback_strand),
    .rollback_pc         (rollback_pc),
    .strand_sleeping     (strand_sleeping)
`ifdef STRAND_WAKE_PERF_EN
    ,
    .pc_event_strand_suspend (pc_event_strand_suspend),
    .pc_event_retry_backoff  (pc_event_retry_backoff)
`endif
  );

  always #5 clk = ~clk;

  // Issue one rollback event from a negedge; returns at the negedge right
  // after the capturing posedge with the request already dropped.
  task automatic send_event(input logic [1:0] s, input logic susp, input logic rty,
                            input logic [31:0] pc, input logic [3:0] res);
    @(negedge clk);
    wb_rollback_request = 1'b1;
    wb_strand           = s;
    wb_suspend_request  = susp;
    wb_retry            = rty;
    wb_rollback_pc      = pc;
    resume_strands      = res;
    @(negedge clk);
    wb_rollback_request = 1'b0;
    wb_suspend_request  = 1'b0;
    wb_retry            = 1'b0;
    resume_strands      = 4'b0000;
  endtask

  // Retry on strand 0, then count negedge samples with ready[0] low.
  task automatic retry_low_cycles(output int low);
    send_event(2'd0, 1'b0, 1'b1, 32'h2000, 4'b0000);
    low = 0;
    while (strand_ready[0] === 1'b0 && low < 20) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset               = 1'b1;
    wb_rollback_request = 1'b0;
    wb_rollback_pc      = 32'h0;
    wb_suspend_request  = 1'b0;
    wb_retry            = 1'b0;
    wb_strand           = 2'd0;
    resume_strands      = 4'b0000;
    strand_enable       = 4'b1111;
    repeat (3) @(negedge clk);
    total++;
    if (strand_ready !== 4'b1111) begin bad++; $display("FAIL reset_ready got=%b exp=1111", strand_ready); end
    total++;
    if (rollback_en !== 1'b0 || rollback_strand !== 2'd0 || rollback_pc !== 32'h0) begin
      bad++; $display("FAIL reset_rollback got en=%b s=%0d pc=%h exp 0/0/0", rollback_en, rollback_strand, rollback_pc);
    end
    total++;
    if (strand_sleeping !== 4'b0000) begin bad++; $display("FAIL reset_sleeping got=%b exp=0000", strand_sleeping); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_suspend_resume;
    send_event(2'd2, 1'b1, 1'b0, 32'h1000, 4'b0000);
    total++;
    if (rollback_en !== 1'b1 || rollback_strand !== 2'd2 || rollback_pc !== 32'h1000) begin
      bad++; $display("FAIL susp_rollback got en=%b s=%0d pc=%h exp 1/2/00001000", rollback_en, rollback_strand, rollback_pc);
    end
    total++;
    if (strand_ready !== 4'b1011) begin bad++; $display("FAIL susp_ready got=%b exp=1011", strand_ready); end
    total++;
    if (strand_sleeping !== 4'b0100) begin bad++; $display("FAIL susp_sleeping got=%b exp=0100", strand_sleeping); end
    @(negedge clk);
    total++;
    if (rollback_en !== 1'b0) begin bad++; $display("FAIL susp_en_drop got=%b exp=0", rollback_en); end
    total++;
    if (strand_ready !== 4'b1011) begin bad++; $display("FAIL susp_hold got=%b exp=1011", strand_ready); end
    resume_strands = 4'b0100;
    @(negedge clk);
    resume_strands = 4'b0000;
    total++;
    if (strand_ready !== 4'b1111 || strand_sleeping !== 4'b0000) begin
      bad++; $display("FAIL resume_ready got ready=%b sleep=%b exp 1111/0000", strand_ready, strand_sleeping);
    end
  endtask

  task automatic test_same_cycle_resume;
    send_event(2'd1, 1'b1, 1'b0, 32'h1100, 4'b0010);
    total++;
    if (strand_ready !== 4'b1111 || strand_sleeping !== 4'b0000) begin
      bad++; $display("FAIL same_cycle got ready=%b sleep=%b exp 1111/0000", strand_ready, strand_sleeping);
    end
    total++;
    if (rollback_en !== 1'b1 || rollback_strand !== 2'd1) begin
      bad++; $display("FAIL same_cycle_rb got en=%b s=%0d exp 1/1", rollback_en, rollback_strand);
    end
  endtask

  task automatic test_backoff;
    int low;
    int exp_tbl [9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
    for (int i = 0; i < 9; i++) begin
      retry_low_cycles(low);
      total++;
      if (low !== exp_tbl[i]) begin
        bad++; $display("FAIL backoff_retry%0d got=%0d exp=%0d", i + 1, low, exp_tbl[i]);
      end
    end
    // Suspend clears the retry history; the next retry starts over at 1.
    send_event(2'd0, 1'b1, 1'b0, 32'h3000, 4'b0000);
    total++;
    if (strand_sleeping !== 4'b0001) begin bad++; $display("FAIL backoff_susp got=%b exp=0001", strand_sleeping); end
    resume_strands = 4'b0001;
    @(negedge clk);
    resume_strands = 4'b0000;
    retry_low_cycles(low);
    total++;
    if (low !== 1) begin bad++; $display("FAIL backoff_after_resume got=%0d exp=1", low); end
  endtask

  task automatic test_disable;
    send_event(2'd3, 1'b1, 1'b0, 32'h4000, 4'b0000);
    total++;
    if (strand_sleeping !== 4'b1000) begin bad++; $display("FAIL dis_pre_sleep got=%b exp=1000", strand_sleeping); end
    strand_enable = 4'b0111;
    @(negedge clk);
    total++;
    if (strand_sleeping !== 4'b0000 || strand_ready !== 4'b0111) begin
      bad++; $display("FAIL dis_forced got sleep=%b ready=%b exp 0000/0111", strand_sleeping, strand_ready);
    end
    strand_enable = 4'b1111;
    #1;
    total++;
    if (strand_ready !== 4'b1111) begin bad++; $display("FAIL dis_reenable got=%b exp=1111", strand_ready); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int low;
    // Strand 0 retry history is 1 here; walk loads 2..5, then load 6.
    for (int i = 0; i < 4; i++) begin
      retry_low_cycles(low);
      total++;
      if (low !== i + 2) begin bad++; $display("FAIL mid_ramp%0d got=%0d exp=%0d", i, low, i + 2); end
    end
    send_event(2'd0, 1'b0, 1'b1, 32'h5000, 4'b0000);
    @(negedge clk);
    total++;
    if (dut.backoff_cnt[0] !== 3'd5 || strand_ready[0] !== 1'b0) begin
      bad++; $display("FAIL mid_pre got cnt=%0d ready0=%b exp 5/0", dut.backoff_cnt[0], strand_ready[0]);
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (strand_ready !== 4'b1111 || dut.backoff_cnt[0] !== 3'd0 || dut.retry_cnt[0] !== 3'd0) begin
      bad++; $display("FAIL mid_reset got ready=%b cnt=%0d retry=%0d exp 1111/0/0",
                      strand_ready, dut.backoff_cnt[0], dut.retry_cnt[0]);
    end
    total++;
    if (rollback_en !== 1'b0 || rollback_pc !== 32'h0) begin
      bad++; $display("FAIL mid_reset_rb got en=%b pc=%h exp 0/0", rollback_en, rollback_pc);
    end
    retry_low_cycles(low);
    total++;
    if (low !== 1) begin bad++; $display("FAIL mid_after got=%0d exp=1", low); end
  endtask

  initial begin
    test_reset();
    test_suspend_resume();
    test_same_cycle_resume();
    test_backoff();
    test_disable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
